// File: rtl/frame_buffer_streamer_pkg.sv
// Shared definitions for the frame-buffer streamer: command codes and FSM state encoding.
package frame_buffer_streamer_pkg;

  localparam logic [7:0] FBS_NOP     = 8'd0;
  localparam logic [7:0] FBS_READ    = 8'd2;
  localparam logic [7:0] FBS_CAPTURE = 8'd3;
  localparam logic [7:0] FBS_ABORT   = 8'd4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_CAPTURE  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_SEND     = 3'd5
  } fbs_state_t;

endpackage

// File: rtl/frame_buffer_streamer_packer.sv
// Packet assembly register: PPP pixel slots, written one slot at a time, cleared to zero
// so that unfilled slots of a short final packet read as 0.
module frame_buffer_streamer_packer #(
  parameter int PIX_W  = 16,
  parameter int PPP    = 16,
  parameter int SLOT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [SLOT_W-1:0]      wr_slot,
  input  logic [PIX_W-1:0]       wr_data,
  output logic [PPP*PIX_W-1:0]   pkt_data
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pkt_data <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < PPP; k++) begin
        if (wr_slot == SLOT_W'(k)) pkt_data[k*PIX_W +: PIX_W] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/frame_buffer_streamer.sv
// Frame-buffer engine: captures one camera frame into pixel RAM, then streams it back
// as fixed-size packets over a valid/ready interface.
module frame_buffer_streamer
  import frame_buffer_streamer_pkg::*;
#(
  parameter int PIX_W        = 16,
  parameter int ADDR_W       = 17,
  parameter int FRAME_PIXELS = 57600,
  parameter int PKT_BYTES    = 32,
  parameter int RAM_LAT      = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  input  logic [7:0]             cmd,
  output logic                   cap_start,
  input  logic                   cam_new_img,
  input  logic                   cam_valid,
  input  logic [PIX_W-1:0]       cam_data,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic                   ram_we,
  output logic [PIX_W-1:0]       ram_wdata,
  input  logic [PIX_W-1:0]       ram_rdata,
  output logic                   pkt_valid,
  input  logic                   pkt_ready,
  output logic [PKT_BYTES*8-1:0] pkt_data,
  output logic                   busy,
  output logic                   frame_ready,
  output logic                   overflow,
  output logic [ADDR_W:0]        frame_len
);

  localparam int PPP    = PKT_BYTES * 8 / PIX_W;
  localparam int SLOT_W = (PPP > 1) ? $clog2(PPP) : 1;
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FP_C  = CNT_W'(FRAME_PIXELS);
  localparam logic [2:0]       LAT_C = 3'(RAM_LAT);

  fbs_state_t state, state_nxt;

  logic [CNT_W-1:0]  wr_ptr, wr_ptr_nxt, rd_ptr;
  logic [SLOT_W-1:0] slot;
  logic [2:0]        lat_cnt;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [PIX_W-1:0]  wr_data_p1;

  logic cmd_abort, cmd_read, cmd_capture;
  logic wr_room, pix_wr, cap_done, rd_start, lat_hit, rd_last, last_slot, pkt_accept;

  assign cmd_abort   = cmd_valid && (cmd == FBS_ABORT);
  assign cmd_read    = cmd_valid && (cmd == FBS_READ);
  assign cmd_capture = cmd_valid && (cmd == FBS_CAPTURE);

  assign wr_room    = wr_ptr < FP_C;
  assign pix_wr     = (state == ST_CAPTURE) && cam_valid && wr_room;
  assign wr_ptr_nxt = wr_ptr + CNT_W'(pix_wr);
  // The full-frame exit is taken on the registered pointer, so a pixel arriving right
  // after the last stored one is seen in CAPTURE and flagged as overflow.
  assign cap_done   = (state == ST_CAPTURE) && (cam_new_img || (wr_ptr == FP_C));

  assign rd_start   = (state == ST_IDLE) && cmd_read && frame_ready && (frame_len != '0);
  assign lat_hit    = (state == ST_RD_WAIT) && (lat_cnt == LAT_C);
  assign rd_last    = (rd_ptr + 1'b1) >= frame_len;
  assign last_slot  = slot == SLOT_W'(PPP - 1);
  assign pkt_accept = (state == ST_SEND) && pkt_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    pkt_valid = (state == ST_SEND);
    if (cmd_abort) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_capture)   state_nxt = ST_ARM;
          else if (rd_start) state_nxt = ST_RD_ISSUE;
        end
        ST_ARM:      if (cam_new_img) state_nxt = ST_CAPTURE;
        ST_CAPTURE:  if (cap_done) state_nxt = ST_IDLE;
        ST_RD_ISSUE: state_nxt = ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (lat_hit) state_nxt = (last_slot || rd_last) ? ST_SEND : ST_RD_ISSUE;
        end
        ST_SEND: begin
          if (pkt_ready) state_nxt = (rd_ptr < frame_len) ? ST_RD_ISSUE : ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Capture side: one-cycle write pipeline, frame status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_start   <= 1'b0;
      ram_we      <= 1'b0;
      wr_addr_p1  <= '0;
      wr_ptr      <= '0;
      frame_ready <= 1'b0;
      overflow    <= 1'b0;
      frame_len   <= '0;
    end else begin
      cap_start <= (state == ST_IDLE) && cmd_capture;
      ram_we    <= pix_wr && !cmd_abort;
      if (pix_wr) begin
        wr_addr_p1 <= wr_ptr[ADDR_W-1:0];
        wr_ptr     <= wr_ptr_nxt;
      end
      if ((state == ST_CAPTURE) && cam_valid && !wr_room) overflow <= 1'b1;
      if (cap_done && !cmd_abort) begin
        frame_len   <= wr_ptr_nxt;
        frame_ready <= 1'b1;
      end
      if ((state == ST_IDLE) && cmd_capture) begin
        frame_ready <= 1'b0;
        overflow    <= 1'b0;
        wr_ptr      <= '0;
      end
      if (cmd_abort && ((state == ST_ARM) || (state == ST_CAPTURE))) frame_ready <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pix_wr) wr_data_p1 <= cam_data;
  end

  assign ram_wdata = wr_data_p1;
  assign ram_addr  = ((state == ST_RD_ISSUE) || (state == ST_RD_WAIT)) ? rd_ptr[ADDR_W-1:0]
                                                                       : wr_addr_p1;

  // Readout side: pointer, slot and RAM latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      slot    <= '0;
      lat_cnt <= 3'd1;
    end else if (cmd_abort || rd_start) begin
      rd_ptr <= '0;
      slot   <= '0;
    end else begin
      case (state)
        ST_RD_ISSUE: lat_cnt <= 3'd1;
        ST_RD_WAIT: begin
          if (lat_hit) begin
            rd_ptr <= rd_ptr + 1'b1;
            slot   <= slot + 1'b1;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_SEND: begin
          if (pkt_ready) begin
            slot <= '0;
            if (rd_ptr >= frame_len) rd_ptr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  frame_buffer_streamer_packer #(
    .PIX_W  (PIX_W),
    .PPP    (PPP),
    .SLOT_W (SLOT_W)
  ) u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (rd_start || cmd_abort || pkt_accept),
    .wr_en    (lat_hit && !cmd_abort),
    .wr_slot  (slot),
    .wr_data  (ram_rdata),
    .pkt_data (pkt_data)
  );

endmodule

// File: tb/tb_frame_buffer_streamer.sv
// Directed scoreboard bench: a 64-pixel instance for capture/readout and an
// 8-pixel instance (FRAME_PIXELS == 2**ADDR_W) for the overflow boundary.
module tb_frame_buffer_streamer;
  import frame_buffer_streamer_pkg::*;

  localparam int TB_LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         cmd_valid, cam_new_img, cam_valid, pkt_ready;
  logic [7:0]   cmd;
  logic [15:0]  cam_data, ram_wdata, ram_rdata;
  logic [6:0]   ram_addr;
  logic         cap_start, ram_we, pkt_valid, busy, frame_ready, overflow;
  logic [255:0] pkt_data;
  logic [7:0]   frame_len;

  logic         s_cmd_valid, s_cam_new_img, s_cam_valid;
  logic [7:0]   s_cmd;
  logic [15:0]  s_cam_data, s_ram_wdata, s_ram_rdata;
  logic [2:0]   s_ram_addr;
  logic         s_cap_start, s_ram_we, s_pkt_valid, s_busy, s_frame_ready, s_overflow;
  logic [255:0] s_pkt_data;
  logic [3:0]   s_frame_len;

  frame_buffer_streamer #(.PIX_W(16), .ADDR_W(7), .FRAME_PIXELS(64), .PKT_BYTES(32),
                          .RAM_LAT(TB_LAT)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd), .cap_start(cap_start),
    .cam_new_img(cam_new_img), .cam_valid(cam_valid), .cam_data(cam_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_data(pkt_data), .busy(busy),
    .frame_ready(frame_ready), .overflow(overflow), .frame_len(frame_len));

  frame_buffer_streamer #(.PIX_W(16), .ADDR_W(3), .FRAME_PIXELS(8), .PKT_BYTES(32),
                          .RAM_LAT(1)) dut_s (
    .clk(clk), .reset(reset), .cmd_valid(s_cmd_valid), .cmd(s_cmd), .cap_start(s_cap_start),
    .cam_new_img(s_cam_new_img), .cam_valid(s_cam_valid), .cam_data(s_cam_data),
    .ram_addr(s_ram_addr), .ram_we(s_ram_we), .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata),
    .pkt_valid(s_pkt_valid), .pkt_ready(1'b1), .pkt_data(s_pkt_data), .busy(s_busy),
    .frame_ready(s_frame_ready), .overflow(s_overflow), .frame_len(s_frame_len));

  assign s_ram_rdata = 16'h0000;

  // RAM model with TB_LAT cycles of read latency
  logic [15:0] mem [0:127];
  logic [15:0] pipe [0:TB_LAT-1];
  assign ram_rdata = pipe[TB_LAT-1];
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    pipe[0] <= mem[ram_addr];
    for (int i = 1; i < TB_LAT; i++) pipe[i] <= pipe[i-1];
  end

  int n_chk = 0, n_fail = 0;
  int n_wr = 0, s_n_wr = 0, n_pkt = 0;
  int wq_a[$], sq_a[$];
  logic [15:0] wq_d[$], sq_d[$];
  logic [255:0] pq[$];
  logic [15:0] fr [0:63];
  int fr_len = 0;
  logic cap_seen;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] exp_pkt(input int p);
    logic [255:0] r = '0;
    for (int k = 0; k < 16; k++)
      if (p*16 + k < fr_len) r[k*16 +: 16] = fr[p*16 + k];
    return r;
  endfunction

  // Scoreboard monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (wq_a.size() == 0) chk("wr_extra", 256'(wq_a.size()), 256'd1);
      else begin
        chk("wr_addr", ram_addr, wq_a.pop_front());
        chk("wr_data", ram_wdata, wq_d.pop_front());
        n_wr++;
      end
    end
    if (s_ram_we === 1'b1) begin
      if (sq_a.size() == 0) chk("s_wr_extra", 256'(sq_a.size()), 256'd1);
      else begin
        chk("s_wr_addr", s_ram_addr, sq_a.pop_front());
        chk("s_wr_data", s_ram_wdata, sq_d.pop_front());
        s_n_wr++;
      end
    end
    if (pkt_valid === 1'b1 && pkt_ready === 1'b1) begin
      if (pq.size() == 0) chk("pkt_extra", 256'(pq.size()), 256'd1);
      else begin
        chk("pkt_data", pkt_data, pq.pop_front());
        n_pkt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
    cmd = FBS_NOP;
  endtask

  task automatic capture(input int n, input logic [15:0] base);
    send_cmd(FBS_CAPTURE);
    cap_seen = cap_start;
    cam_new_img = 1'b1;
    tick();
    cam_new_img = 1'b0;
    for (int i = 0; i < n; i++) begin
      cam_valid = 1'b1;
      cam_data = base + 16'(i);
      fr[i] = base + 16'(i);
      wq_a.push_back(i);
      wq_d.push_back(base + 16'(i));
      tick();
    end
    cam_valid = 1'b0;
    cam_new_img = 1'b1;
    tick();
    cam_new_img = 1'b0;
    fr_len = n;
    tick();
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 400) begin
      tick();
      k++;
    end
    chk(tag, busy, 1'b0);
  endtask

  task automatic wait_pkts(input int target);
    int k = 0;
    while (n_pkt < target && k < 400) begin
      tick();
      k++;
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (pkt_valid !== 1'b1 && k < 400) begin
      tick();
      k++;
    end
    chk(tag, pkt_valid, 1'b1);
  endtask

  initial begin
    int b;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd = FBS_NOP; cam_new_img = 1'b0; cam_valid = 1'b0;
    cam_data = '0; pkt_ready = 1'b0;
    s_cmd_valid = 1'b0; s_cmd = FBS_NOP; s_cam_new_img = 1'b0; s_cam_valid = 1'b0;
    s_cam_data = '0;
    repeat (3) tick();
    reset = 1'b0;

    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_cap_start", cap_start, 0);
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_pkt_data", pkt_data, 0);
    chk("rst_frame_ready", frame_ready, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_pkt_data", s_pkt_data, 0);
    chk("rst_s_frame_len", s_frame_len, 0);

    // Test 1: 10-pixel capture
    b = n_wr;
    capture(10, 16'h0001);
    chk("t1_cap_start", cap_seen, 1'b1);
    chk("t1_writes", 256'(n_wr - b), 256'd10);
    chk("t1_frame_len", frame_len, 8'd10);
    chk("t1_frame_ready", frame_ready, 1'b1);
    chk("t1_overflow", overflow, 1'b0);
    chk("t1_busy", busy, 1'b0);

    // Test 2: one short packet, slots 10..15 zero
    b = n_pkt;
    pq.push_back(exp_pkt(0));
    pkt_ready = 1'b1;
    send_cmd(FBS_READ);
    wait_idle("t2_idle");
    chk("t2_pkts", 256'(n_pkt - b), 256'd1);
    chk("t2_frame_ready", frame_ready, 1'b1);

    // Test 3: 12 pixels into an 8-pixel frame
    s_cmd_valid = 1'b1; s_cmd = FBS_CAPTURE;
    tick();
    s_cmd_valid = 1'b0; s_cmd = FBS_NOP;
    chk("t3_cap_start", s_cap_start, 1'b1);
    s_cam_new_img = 1'b1;
    tick();
    s_cam_new_img = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) chk("t3_busy_last", s_busy, 1'b1);
      if (i == 9) chk("t3_busy_exit", s_busy, 1'b0);
      s_cam_valid = 1'b1;
      s_cam_data = 16'h0C00 + 16'(i);
      if (i < 8) begin
        sq_a.push_back(i);
        sq_d.push_back(16'h0C00 + 16'(i));
      end
      tick();
    end
    s_cam_valid = 1'b0;
    tick();
    chk("t3_writes", 256'(s_n_wr), 256'd8);
    chk("t3_overflow", s_overflow, 1'b1);
    chk("t3_frame_len", s_frame_len, 4'd8);
    chk("t3_frame_ready", s_frame_ready, 1'b1);

    // Test 4: 40 pixels, stall on packet 2
    capture(40, 16'h0100);
    chk("t4_frame_len", frame_len, 8'd40);
    b = n_pkt;
    for (int p = 0; p < 3; p++) pq.push_back(exp_pkt(p));
    pkt_ready = 1'b1;
    send_cmd(FBS_READ);
    wait_pkts(b + 1);
    pkt_ready = 1'b0;
    chk("t4_pkt1", 256'(n_pkt - b), 256'd1);
    wait_valid("t4_valid");
    for (int i = 0; i < 20; i++) begin
      chk("t4_stall_valid", pkt_valid, 1'b1);
      chk("t4_stall_data", pkt_data, pq[0]);
      tick();
    end
    pkt_ready = 1'b1;
    wait_idle("t4_idle");
    chk("t4_pkts", 256'(n_pkt - b), 256'd3);

    // Test 5: ABORT while packet 2 is pending
    b = n_pkt;
    pq.push_back(exp_pkt(0));
    pkt_ready = 1'b1;
    send_cmd(FBS_READ);
    wait_pkts(b + 1);
    pkt_ready = 1'b0;
    wait_valid("t5_valid");
    send_cmd(FBS_ABORT);
    chk("t5_busy", busy, 1'b0);
    chk("t5_pkt_valid", pkt_valid, 1'b0);
    chk("t5_frame_ready", frame_ready, 1'b1);
    chk("t5_frame_len", frame_len, 8'd40);
    b = n_pkt;
    for (int p = 0; p < 3; p++) pq.push_back(exp_pkt(p));
    pkt_ready = 1'b1;
    send_cmd(FBS_READ);
    wait_idle("t5_idle");
    chk("t5_pkts", 256'(n_pkt - b), 256'd3);

    // Test 6: reset mid-capture with cam_valid active
    send_cmd(FBS_CAPTURE);
    cam_new_img = 1'b1;
    tick();
    cam_new_img = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cam_valid = 1'b1;
      cam_data = 16'h00A1 + 16'(i);
      wq_a.push_back(i);
      wq_d.push_back(16'h00A1 + 16'(i));
      tick();
    end
    reset = 1'b1;
    cam_data = 16'h00EE;
    tick();
    chk("t6_ram_we", ram_we, 1'b0);
    chk("t6_ram_addr", ram_addr, 0);
    chk("t6_cap_start", cap_start, 1'b0);
    chk("t6_pkt_valid", pkt_valid, 1'b0);
    chk("t6_pkt_data", pkt_data, 0);
    chk("t6_frame_ready", frame_ready, 1'b0);
    chk("t6_overflow", overflow, 1'b0);
    chk("t6_frame_len", frame_len, 0);
    chk("t6_busy", busy, 1'b0);
    tick();
    chk("t6_ram_we_hold", ram_we, 1'b0);
    reset = 1'b0;
    cam_valid = 1'b0;
    tick();
    send_cmd(FBS_READ);
    chk("t6_read_no_frame", busy, 1'b0);
    send_cmd(FBS_CAPTURE);
    chk("t6_arm_cap_start", cap_start, 1'b1);
    chk("t6_arm_busy", busy, 1'b1);
    send_cmd(FBS_CAPTURE);
    chk("t6_arm_cap_ignored", cap_start, 1'b0);
    chk("t6_arm_still_busy", busy, 1'b1);
    send_cmd(FBS_ABORT);
    chk("t6_abort_busy", busy, 1'b0);
    chk("t6_abort_frame_ready", frame_ready, 1'b0);
    repeat (2) tick();

    chk("end_wq_empty", 256'(wq_a.size()), 256'd0);
    chk("end_sq_empty", 256'(sq_a.size()), 256'd0);
    chk("end_pq_empty", 256'(pq.size()), 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
